// File: rtl/spi_ram_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_pkg
// Shared types and constants for the SPI slave front end of the single-port
// RAM: controller state encoding, 2-bit command codes carried in the top two
// bits of every frame, and the frame-width helper (payload + 2 command bits).
// No ports.
// -----------------------------------------------------------------------------
package spi_ram_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

    // Command codes as seen in rx_data[FRAME_W-1 -: 2].
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    function automatic int frame_w(input int dw);
        return dw + 2;
    endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_slave_ctrl_if
// RAM-side command/response bundle of the SPI slave controller.
//   rx_data  [FRAME_W-1:0]  assembled frame, [FRAME_W-1:FRAME_W-2] command
//   rx_valid                one-cycle strobe qualifying rx_data
//   tx_data  [DATA_W-1:0]   RAM read data
//   tx_valid                RAM read-valid (sticky level, may be stale-high)
// Modports: slave  = SPI controller side (drives rx_*, consumes tx_*)
//           master = RAM side (consumes rx_*, drives tx_*)
// -----------------------------------------------------------------------------
interface spi_slave_ctrl_if
    import spi_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    localparam int FRAME_W = frame_w(DATA_W);

    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport slave  (output rx_data, output rx_valid, input  tx_data, input  tx_valid);
    modport master (input  rx_data, input  rx_valid, output tx_data, output tx_valid);

endinterface

// File: rtl/spi_tx_shifter.sv
// -----------------------------------------------------------------------------
// spi_tx_shifter
// Parallel-load, MSB-first serialiser for RAM read data onto MISO.
//   clk, rst_n  clock, async active-low reset
//   clr         synchronous abort: drop any byte in flight, MISO -> 0
//   load        capture din; din[MSB] appears on miso the following cycle
//   din         byte to send
//   miso        registered serial output, 0 whenever idle
//   busy        a byte is being shifted out
//   done        one-cycle pulse the cycle after the last bit has been driven
// -----------------------------------------------------------------------------
module spi_tx_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              miso,
    output logic              busy,
    output logic              done
);
    localparam int BCNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] sr;
    logic [BCNT_W-1:0] bcnt;   // bits still waiting in sr after the one on miso

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            bcnt <= '0;
            miso <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                sr   <= '0;
                bcnt <= '0;
                miso <= 1'b0;
                busy <= 1'b0;
            end else if (load) begin
                // MSB goes straight to miso so it is on the pin the very next cycle.
                miso <= din[DATA_W-1];
                sr   <= {din[DATA_W-2:0], 1'b0};
                bcnt <= BCNT_W'(DATA_W - 1);
                busy <= 1'b1;
            end else if (busy) begin
                if (bcnt != '0) begin
                    miso <= sr[DATA_W-1];
                    sr   <= {sr[DATA_W-2:0], 1'b0};
                    bcnt <= bcnt - 1'b1;
                end else begin
                    miso <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// spi_slave_ctrl
// SPI mode-0 slave front end for the single-port RAM. Pins are sampled on the
// system clock. Each SS_n-low transaction carries one frame of DATA_W+2 bits,
// MSB first: two command bits then DATA_W payload bits. Completed frames are
// presented on bus.rx_data with a one-cycle bus.rx_valid strobe. A read-data
// frame (command 1x issued after a read-address frame) then captures RAM read
// data and shifts it out on MISO.
//   clk, rst_n  clock, async active-low reset
//   SS_n        slave select, active low
//   MOSI        serial data in
//   MISO        serial data out (registered)
//   bus         spi_slave_ctrl_if.slave: rx_data/rx_valid out, tx_data/tx_valid in
// -----------------------------------------------------------------------------
module spi_slave_ctrl
    import spi_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SS_n,
    input  logic             MOSI,
    output logic             MISO,
    spi_slave_ctrl_if.slave  bus
);
    localparam int FRAME_W = frame_w(DATA_W);
    localparam int CNT_W   = $clog2(DATA_W + 5);

    // Bit counter phases inside WRITE/READ_ADD/READ_DATA:
    //   0..C_LAST  payload shifts; the shift at C_LAST completes the frame
    //   C_ARM      cycle c (rx_valid high); RAM dout not yet updated, never sample
    //   C_WAIT     sample tx_data on the first edge with tx_valid=1
    //   C_SHIFT    byte on MISO
    //   C_FIN      nothing more until SS_n rises
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] C_ARM   = CNT_W'(DATA_W + 1);
    localparam logic [CNT_W-1:0] C_WAIT  = CNT_W'(DATA_W + 2);
    localparam logic [CNT_W-1:0] C_SHIFT = CNT_W'(DATA_W + 3);
    localparam logic [CNT_W-1:0] C_FIN   = CNT_W'(DATA_W + 4);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] rx_data_q;
    logic               rx_valid_q;
    logic               rd_addr_done;

    logic tx_load;
    logic tx_busy;
    logic tx_done;

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

    // SS_n high has priority, so a capture can never race an abort.
    assign tx_load = (state == READ_DATA) && (cnt == C_WAIT) && bus.tx_valid
                     && !SS_n && !tx_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rd_addr_done <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (state != IDLE && SS_n) begin
                // Abort / end of transaction: any partial frame is dropped.
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!SS_n) begin
                            state <= CHK_CMD;
                            cnt   <= '0;
                        end
                    end
                    CHK_CMD: begin
                        rx_data_q[FRAME_W-1] <= MOSI;
                        cnt                  <= '0;
                        if (!MOSI)             state <= WRITE;
                        else if (rd_addr_done) state <= READ_DATA;
                        else                   state <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (cnt <= C_LAST) begin
                            rx_data_q[FRAME_W-2:0] <= {rx_data_q[FRAME_W-3:0], MOSI};
                            cnt <= cnt + 1'b1;
                            if (cnt == C_LAST) begin
                                rx_valid_q <= 1'b1;
                                if (state == READ_ADD)  rd_addr_done <= 1'b1;
                                if (state == READ_DATA) rd_addr_done <= 1'b0;
                            end
                        end else if (state == READ_DATA) begin
                            case (cnt)
                                C_ARM:   cnt <= C_WAIT;
                                C_WAIT:  if (tx_load) cnt <= C_SHIFT;
                                C_SHIFT: if (tx_done) cnt <= C_FIN;
                                default: ;
                            endcase
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    spi_tx_shifter #(.DATA_W(DATA_W)) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (SS_n),
        .load  (tx_load),
        .din   (bus.tx_data),
        .miso  (MISO),
        .busy  (tx_busy),
        .done  (tx_done)
    );

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_ctrl
// Directed stimulus drives SPI frames and a small RAM read-data model; each
// frame expected to complete pushes its expected rx_data, arrival cycle and
// MISO behaviour into a queue that an independent monitor pops on rx_valid.
// -----------------------------------------------------------------------------
module tb_spi_slave_ctrl;
    import spi_ram_pkg::*;

    logic clk = 1'b0;
    logic rst_n, SS_n, MOSI, MISO;

    spi_slave_ctrl_if #(.DATA_W(8)) bus();

    spi_slave_ctrl #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .SS_n  (SS_n),
        .MOSI  (MOSI),
        .MISO  (MISO),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // kind: 0 = no MISO check, 1 = MISO must stay 0, 2 = MISO must carry mbyte
    typedef struct {
        logic [9:0] data;
        int         cyc;
        int         kind;
        logic [7:0] mbyte;
        int         mdelay;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0, n_bad = 0, n_exp = 0, n_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t       e;
        logic [7:0] got;
        logic       zeros;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.rx_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rx_valid: got rx_data=%0h expected no strobe", bus.rx_data);
                end else begin
                    e = exp_q.pop_front();
                    n_seen++;
                    chk("rx_data", 32'(bus.rx_data), 32'(e.data));
                    chk("rx_valid_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.kind == 1) begin
                        zeros = 1'b1;
                        for (int i = 0; i < 10; i++) begin
                            if (MISO !== 1'b0) zeros = 1'b0;
                            @(negedge clk);
                        end
                        chk("miso_quiet", 32'(zeros), 32'd1);
                    end else if (e.kind == 2) begin
                        zeros = 1'b1;
                        for (int d = 0; d < e.mdelay; d++) begin
                            if (MISO !== 1'b0) zeros = 1'b0;
                            @(negedge clk);
                        end
                        chk("miso_lead_zero", 32'(zeros), 32'd1);
                        got = '0;
                        for (int b = 0; b < 8; b++) begin
                            got = {got[6:0], MISO};
                            @(negedge clk);
                        end
                        chk("miso_byte", 32'(got), 32'(e.mbyte));
                        chk("miso_trail_zero", 32'(MISO), 32'd0);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drops SS_n, then drives nbits of f MSB first, one per cycle.
    task automatic start_frame(input logic [9:0] f, input int nbits, input bit pulse,
                               input int kind, input logic [7:0] mbyte, input int mdelay);
        exp_t e;
        @(negedge clk);
        SS_n = 1'b0;
        if (pulse) begin
            e.data = f; e.cyc = cyc + 11; e.kind = kind; e.mbyte = mbyte; e.mdelay = mdelay;
            exp_q.push_back(e);
            n_exp++;
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            MOSI = f[9-i];
        end
    endtask

    task automatic end_frame(input int hold);
        repeat (hold) @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
    endtask

    // Read-data frame plus the RAM model: new dout at c+1 (+late cycles).
    task automatic rd_data(input logic [9:0] f, input logic [7:0] b, input int late, input int kind);
        start_frame(f, 10, 1'b1, kind, b, 2 + late);
        @(negedge clk);
        repeat (late) @(negedge clk);
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : stim
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        bus.tx_data = '0; bus.tx_valid = 1'b0;
        #2;
        chk("rst_miso", 32'(MISO), 32'd0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_rd_addr_done", 32'(dut.rd_addr_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Write address / write data
        start_frame({CMD_WR_ADDR, 8'h05}, 10, 1'b1, 1, 8'h00, 0);
        end_frame(12);
        chk("wr_addr_rd_done", 32'(dut.rd_addr_done), 32'd0);
        start_frame({CMD_WR_DATA, 8'hAA}, 10, 1'b1, 1, 8'h00, 0);
        end_frame(12);

        // Read address then read data, RAM answers at c+1
        start_frame({CMD_RD_ADDR, 8'h05}, 10, 1'b1, 1, 8'h00, 0);
        end_frame(12);
        chk("rd_addr_set", 32'(dut.rd_addr_done), 32'd1);
        rd_data({CMD_RD_DATA, 8'h55}, 8'hAA, 0, 2);
        end_frame(12);
        chk("rd_data_clr", 32'(dut.rd_addr_done), 32'd0);

        // Stale-high tx_valid with old data AA; new data 3C only at c+1
        start_frame({CMD_RD_ADDR, 8'h10}, 10, 1'b1, 1, 8'h00, 0);
        end_frame(12);
        rd_data({CMD_RD_DATA, 8'h00}, 8'h3C, 0, 2);
        end_frame(12);

        // tx_valid low until two cycles late
        bus.tx_valid = 1'b0;
        start_frame({CMD_RD_ADDR, 8'h11}, 10, 1'b1, 1, 8'h00, 0);
        end_frame(12);
        rd_data({CMD_RD_DATA, 8'hFF}, 8'h96, 2, 2);
        end_frame(12);

        // Abort after 6 bits, then a clean frame
        start_frame({CMD_WR_DATA, 8'hFF}, 6, 1'b0, 0, 8'h00, 0);
        end_frame(1);
        chk("abort6_state", 32'(dut.state), 32'(IDLE));
        start_frame({CMD_WR_ADDR, 8'hF0}, 10, 1'b1, 1, 8'h00, 0);
        end_frame(12);

        // SS_n rises on the edge of the 10th bit of a read-address frame
        start_frame({CMD_RD_ADDR, 8'h07}, 9, 1'b0, 0, 8'h00, 0);
        end_frame(1);
        chk("abort10_state", 32'(dut.state), 32'(IDLE));
        chk("abort10_rd_done", 32'(dut.rd_addr_done), 32'd0);

        // Reset while READ_DATA is shifting
        start_frame({CMD_RD_ADDR, 8'hAB}, 10, 1'b1, 1, 8'h00, 0);
        end_frame(12);
        rd_data({CMD_RD_DATA, 8'h00}, 8'hFF, 0, 0);
        repeat (3) @(negedge clk);
        chk("miso_before_rst", 32'(MISO), 32'd1);
        rst_n = 1'b0;
        SS_n  = 1'b1;
        #1;
        chk("midrst_miso", 32'(MISO), 32'd0);
        chk("midrst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("midrst_rd_done", 32'(dut.rd_addr_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.tx_data = 8'hA5;   // tx_valid still high: a READ_DATA misdecode would shift this
        start_frame({CMD_RD_ADDR, 8'h03}, 10, 1'b1, 1, 8'h00, 0);
        end_frame(12);
        chk("post_rst_rd_addr", 32'(dut.rd_addr_done), 32'd1);

        repeat (20) @(negedge clk);
        chk("pulse_count", 32'(n_seen), 32'(n_exp));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
